shift_count_reg: RTL

- Parametrised multi-mode register: the successor to the single-bit D flip-flop.
- WIDTH-bit register with synchronous clear, synchronous set and enable, same priority as the single-bit flop.
- Adds a 3-bit mode select: hold, parallel load, shift, rotate, increment and decrement.
- Used as the general-purpose storage, shifter and counter element in datapaths.

---
 rtl/shift_count_reg.sv | 130 +++++++++++++
 1 files changed

// File: rtl/shift_count_reg.sv
// shift_count_reg: WIDTH-bit multi-mode register (hold, load, shift, rotate,
// increment, decrement) with synchronous clear/set and a registered wrap pulse.
// Priority per edge is clr > set > enable > hold. Reset is asynchronous.
module shift_count_reg #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter logic [WIDTH-1:0]   SET_VALUE   = '1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             set,
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             ser_in_lsb,
  input  logic             ser_in_msb,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             wrap
);

  // Operation encodings carried on the mode input.
  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_INC  = 3'b110,
    MODE_DEC  = 3'b111
  } mode_e;

  mode_e            mode_sel;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] q_next;
  logic             wrap_reg;
  logic             wrap_next;

  // Candidate next values for each bit-moving operation.
  logic [WIDTH-1:0] shl_val;
  logic [WIDTH-1:0] shr_val;
  logic [WIDTH-1:0] rol_val;
  logic [WIDTH-1:0] ror_val;
  logic [WIDTH-1:0] inc_val;
  logic [WIDTH-1:0] dec_val;

  // Counter boundary detection on the current value; these decide the wrap pulse.
  logic at_all_ones;
  logic at_zero;

  assign mode_sel    = mode_e'(mode);
  assign at_all_ones = &q_reg;
  assign at_zero     = ~|q_reg;
  assign inc_val     = q_reg + {{(WIDTH-1){1'b0}}, 1'b1};
  assign dec_val     = q_reg - {{(WIDTH-1){1'b0}}, 1'b1};

  // Per-bit wiring of shifts and rotates: end bits take the serial input
  // (shift) or the bit falling off the opposite end (rotate).
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bits
      if (gi == 0) begin : g_lsb
        assign shl_val[gi] = ser_in_lsb;
        assign rol_val[gi] = q_reg[WIDTH-1];
      end else begin : g_lsb_n
        assign shl_val[gi] = q_reg[gi-1];
        assign rol_val[gi] = q_reg[gi-1];
      end
      if (gi == WIDTH-1) begin : g_msb
        assign shr_val[gi] = ser_in_msb;
        assign ror_val[gi] = q_reg[0];
      end else begin : g_msb_n
        assign shr_val[gi] = q_reg[gi+1];
        assign ror_val[gi] = q_reg[gi+1];
      end
    end
  endgenerate

  // Next-state selection: clr beats set beats enable; wrap only on a counter rollover.
  always_comb begin
    q_next    = q_reg;
    wrap_next = 1'b0;
    if (clr) begin
      q_next = '0;
    end else if (set) begin
      q_next = SET_VALUE;
    end else if (enable) begin
      case (mode_sel)
        MODE_HOLD: q_next = q_reg;
        MODE_LOAD: q_next = d;
        MODE_SHL:  q_next = shl_val;
        MODE_SHR:  q_next = shr_val;
        MODE_ROL:  q_next = rol_val;
        MODE_ROR:  q_next = ror_val;
        MODE_INC: begin
          q_next    = inc_val;
          wrap_next = at_all_ones;
        end
        MODE_DEC: begin
          q_next    = dec_val;
          wrap_next = at_zero;
        end
        default:   q_next = q_reg;
      endcase
    end
  end

  // State register; reset aborts any operation in flight and kills wrap.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q_reg    <= RESET_VALUE;
      wrap_reg <= 1'b0;
    end else begin
      q_reg    <= q_next;
      wrap_reg <= wrap_next;
    end
  end

  // Derived outputs follow q combinationally so they are never stale.
  assign q           = q_reg;
  assign qbar        = ~q_reg;
  assign ser_out_msb = q_reg[WIDTH-1];
  assign ser_out_lsb = q_reg[0];
  assign wrap        = wrap_reg;

endmodule
